// File: rtl/draw_arb_pkg.sv
// ============================================================================
// draw_arb_pkg : shared FSM encoding and VGA field widths for draw_arbiter
// Revision     : 1.0
// ============================================================================
`default_nettype none

package draw_arb_pkg;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_START   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RELEASE = 2'd3;

    localparam int VGA_XW = 9;
    localparam int VGA_YW = 8;
    localparam int VGA_CW = 3;

    localparam int CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/draw_arbiter_rr_pick.sv
// ============================================================================
// rr_pick : wrap-around priority search, first set request at or after ptr
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NREQ = 3,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] pick
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            // ptr < NREQ, so a single subtraction is enough to wrap
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(NREQ)) begin
                sum = sum - (PW+1)'(NREQ);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/draw_arbiter.sv
// ============================================================================
// draw_arbiter : round-robin owner of the shared VGA write port
// Revision     : 1.0
// ============================================================================
`default_nettype none

module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    output logic [NREQ-1:0]          grant,
    output logic [NREQ-1:0]          start,
    input  logic [NREQ-1:0]          eng_done,
    input  logic [VGA_XW*NREQ-1:0]   eng_vga_x,
    input  logic [VGA_YW*NREQ-1:0]   eng_vga_y,
    input  logic [VGA_CW*NREQ-1:0]   eng_vga_colour,
    input  logic [NREQ-1:0]          eng_vga_write,
    output logic [VGA_XW-1:0]        vga_x,
    output logic [VGA_YW-1:0]        vga_y,
    output logic [VGA_CW-1:0]        vga_colour,
    output logic                     vga_write,
    output logic                     busy,
    output logic                     timeout_err,
    input  logic                     clear_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [1:0]      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] start_q, start_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            busy_q;
    logic [NREQ-1:0] pick;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   ptr_next;
    logic            g_done;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick)
    );

    always_comb begin
        gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                gidx = PW'(i);
            end
        end
    end

    assign ptr_next = (gidx == PW'(NREQ-1)) ? '0 : gidx + PW'(1);
    // Only the granted engine's done is honoured
    assign g_done   = |(eng_done & grant_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        start_d = '0;
        cnt_d   = cnt_q;
        err_d   = err_q & ~clear_err;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    grant_d = pick;
                    start_d = pick;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d = '0;
                if (g_done) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = S_RELEASE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (g_done) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    state_d = S_RELEASE;
                end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
                    grant_d = '0;
                    ptr_d   = ptr_next;
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            start_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            start_q <= start_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_write  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                vga_x      = eng_vga_x[VGA_XW*i +: VGA_XW];
                vga_y      = eng_vga_y[VGA_YW*i +: VGA_YW];
                vga_colour = eng_vga_colour[VGA_CW*i +: VGA_CW];
                vga_write  = eng_vga_write[i];
            end
        end
    end

    assign grant       = grant_q;
    assign start       = start_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_arbiter.sv
// ============================================================================
// tb_draw_arbiter : scoreboard bench for draw_arbiter (NREQ=3, TIMEOUT=16)
// Revision        : 1.0
// ============================================================================
`default_nettype none

module tb_draw_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  grant;
    logic [2:0]  start;
    logic [2:0]  eng_done = '0;
    logic [26:0] eng_vga_x;
    logic [23:0] eng_vga_y;
    logic [8:0]  eng_vga_colour;
    logic [2:0]  eng_vga_write = '0;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_write;
    logic        busy;
    logic        timeout_err;
    logic        clear_err = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];

    // Engine i draws at x=100*(i+1), y=10*(i+1), colour=4+i
    assign eng_vga_x      = {9'd300, 9'd200, 9'd100};
    assign eng_vga_y      = {8'd30, 8'd20, 8'd10};
    assign eng_vga_colour = {3'd6, 3'd5, 3'd4};

    always #5 clock = ~clock;

    draw_arbiter #(
        .NREQ    (3),
        .TIMEOUT (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .req            (req),
        .grant          (grant),
        .start          (start),
        .eng_done       (eng_done),
        .eng_vga_x      (eng_vga_x),
        .eng_vga_y      (eng_vga_y),
        .eng_vga_colour (eng_vga_colour),
        .eng_vga_write  (eng_vga_write),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_write      (vga_write),
        .busy           (busy),
        .timeout_err    (timeout_err),
        .clear_err      (clear_err)
    );

    task automatic do_reset;
        @(negedge clock);
        reset     = 1'b0;
        req       = '0;
        eng_done  = '0;
        clear_err = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic wait_start(input int bound, output logic [2:0] seen);
        seen = '0;
        for (int c = 0; c < bound; c++) begin
            @(negedge clock);
            if (start !== 3'b000) begin
                seen = start;
                return;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        eng_vga_write = 3'b111;
        @(negedge clock);
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL rst_grant: got %b want 000", grant); end
        checks++; if (start !== 3'b000) begin errors++; $display("FAIL rst_start: got %b want 000", start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", timeout_err); end
        checks++; if (vga_write !== 1'b0) begin errors++; $display("FAIL rst_vga_write: got %b want 0", vga_write); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single;
        do_reset();
        eng_vga_write = 3'b010;
        @(negedge clock);
        req = 3'b010;
        exp_q.push_back(3'b010);
        @(negedge clock);
        checks++; if (grant !== exp_q[0]) begin errors++; $display("FAIL single_grant: got %b want %b", grant, exp_q[0]); end
        void'(exp_q.pop_front());
        checks++; if (start !== 3'b010) begin errors++; $display("FAIL single_start: got %b want 010", start); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b want 1", busy); end
        checks++; if (vga_x !== 9'd200 || vga_y !== 8'd20 || vga_colour !== 3'd5 || vga_write !== 1'b1) begin
            errors++; $display("FAIL single_vga: got x=%0d y=%0d c=%0d w=%b want 200 20 5 1", vga_x, vga_y, vga_colour, vga_write);
        end
        @(negedge clock);
        checks++; if (start !== 3'b000) begin errors++; $display("FAIL single_start_pulse: got %b want 000", start); end
        checks++; if (grant !== 3'b010 || vga_x !== 9'd200) begin errors++; $display("FAIL single_hold: got grant=%b x=%0d want 010 200", grant, vga_x); end
        eng_done = 3'b010;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        checks++; if (grant !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL single_release: got grant=%b busy=%b want 000 1", grant, busy); end
        checks++; if (vga_write !== 1'b0 || vga_x !== 9'd0) begin errors++; $display("FAIL single_rel_vga: got w=%b x=%0d want 0 0", vga_write, vga_x); end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL single_idle: got busy=%b err=%b want 0 0", busy, timeout_err); end
    endtask

    task automatic test_round_robin;
        logic [2:0] prev;
        logic [2:0] exp;
        int         cd;
        bit         finished;
        do_reset();
        eng_vga_write = 3'b000;
        prev     = '0;
        cd       = -1;
        finished = 1'b0;
        for (int r = 0; r < 2; r++)
            for (int e = 0; e < 3; e++)
                exp_q.push_back(3'(1 << e));
        req = 3'b111;
        for (int c = 0; c < 300 && !finished; c++) begin
            @(negedge clock);
            eng_done = '0;
            if (cd == 0) begin
                eng_done = grant;
                cd = -1;
                if (exp_q.size() == 0) begin
                    req = 3'b000;
                    finished = 1'b1;
                end
            end else if (cd > 0) begin
                cd--;
            end
            if (start !== 3'b000) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 3'b000;
                checks++; if (start !== exp) begin errors++; $display("FAIL rr_order: got %b want %b", start, exp); end
                checks++; if (start === prev) begin errors++; $display("FAIL rr_repeat: got %b twice in a row", start); end
                prev = start;
                cd   = 4;
            end
        end
        checks++; if (!finished || exp_q.size() != 0) begin
            errors++; $display("FAIL rr_incomplete: got %0d grants pending want 0", exp_q.size());
        end
        exp_q.delete();
        @(negedge clock);
        eng_done = '0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rr_end: got busy=%b err=%b want 0 0", busy, timeout_err); end
    endtask

    task automatic test_foreign_done;
        logic [2:0] seen;
        do_reset();
        eng_vga_write = 3'b100;
        req = 3'b001;
        exp_q.push_back(3'b001);
        wait_start(10, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL fd_grant: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        @(negedge clock);
        eng_done = 3'b100;
        @(negedge clock);
        eng_done = 3'b000;
        checks++; if (grant !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL fd_ignore: got grant=%b busy=%b want 001 1", grant, busy); end
        checks++; if (vga_write !== 1'b0 || vga_x !== 9'd100) begin errors++; $display("FAIL fd_vga: got w=%b x=%0d want 0 100", vga_write, vga_x); end
        eng_vga_write = 3'b101;
        #1;
        checks++; if (vga_write !== 1'b1) begin errors++; $display("FAIL fd_vga_eng0: got %b want 1", vga_write); end
        eng_done = 3'b001;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        checks++; if (grant !== 3'b000) begin errors++; $display("FAIL fd_release: got %b want 000", grant); end
        @(negedge clock);
    endtask

    task automatic test_timeout;
        logic [2:0] seen;
        do_reset();
        eng_vga_write = 3'b000;
        req = 3'b010;
        exp_q.push_back(3'b010);
        wait_start(10, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL to_grant: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        repeat (16) @(negedge clock);
        checks++; if (grant !== 3'b010 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_last_wait: got grant=%b err=%b want 010 0", grant, timeout_err); end
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        checks++; if (grant !== 3'b000 || busy !== 1'b1) begin errors++; $display("FAIL to_release: got grant=%b busy=%b want 000 1", grant, busy); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_set_wins: got %b want 1", timeout_err); end
        req = 3'b000;
        repeat (4) @(negedge clock);
        checks++; if (timeout_err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL to_sticky: got err=%b busy=%b want 1 0", timeout_err, busy); end
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        req = 3'b111;
        exp_q.push_back(3'b100);
        wait_start(10, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL to_ptr_adv: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        eng_done = 3'b100;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_reset_in_wait;
        logic [2:0] seen;
        do_reset();
        req = 3'b100;
        exp_q.push_back(3'b100);
        wait_start(10, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL rw_grant: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        repeat (3) @(negedge clock);
        eng_vga_write = 3'b111;
        #1;
        checks++; if (vga_write !== 1'b1 || grant !== 3'b100) begin errors++; $display("FAIL rw_pre: got w=%b grant=%b want 1 100", vga_write, grant); end
        #2 reset = 1'b0;
        #1;
        checks++; if (grant !== 3'b000 || start !== 3'b000 || vga_write !== 1'b0) begin
            errors++; $display("FAIL rw_async: got grant=%b start=%b w=%b want 000 000 0", grant, start, vga_write);
        end
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL rw_async_busy: got busy=%b err=%b want 0 0", busy, timeout_err); end
        @(negedge clock);
        reset = 1'b1;
        req   = 3'b111;
        exp_q.push_back(3'b001);
        wait_start(5, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL rw_first: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        eng_done = 3'b001;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_done_with_start;
        logic [2:0] seen;
        do_reset();
        req = 3'b001;
        exp_q.push_back(3'b001);
        wait_start(10, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL ds_grant: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        eng_done = 3'b001;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        checks++; if (grant !== 3'b000 || busy !== 1'b1 || start !== 3'b000) begin
            errors++; $display("FAIL ds_release: got grant=%b busy=%b start=%b want 000 1 000", grant, busy, start);
        end
        @(negedge clock);
        checks++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin errors++; $display("FAIL ds_idle: got busy=%b err=%b want 0 0", busy, timeout_err); end
        req = 3'b011;
        exp_q.push_back(3'b010);
        wait_start(5, seen);
        checks++; if (seen !== exp_q[0]) begin errors++; $display("FAIL ds_ptr_adv: got %b want %b", seen, exp_q[0]); end
        void'(exp_q.pop_front());
        eng_done = 3'b010;
        req      = 3'b000;
        @(negedge clock);
        eng_done = 3'b000;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_foreign_done();
        test_timeout();
        test_reset_in_wait();
        test_done_with_start();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/draw_arbiter.md
DRAW_ARBITER -- requirements
Module: draw_arbiter

Interface
REQ-001 Parameter NREQ, default 3: number of drawing engines sharing the VGA write port (grid, player, rays).
REQ-002 Parameter TIMEOUT, default 65535: cycles a grant may stay in WAIT before forced release; counter width 16 bits.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 Ports, one per line:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per engine.
- grant  out  NREQ  one-hot, or zero when idle.
- start  out  NREQ  one-cycle start pulse to the granted engine.
- eng_done  in  NREQ  engine done pulse.
- eng_vga_x  in  9*NREQ  packed; engine i occupies [9i+8:9i].
- eng_vga_y  in  8*NREQ  packed.
- eng_vga_colour  in  3*NREQ  packed.
- eng_vga_write  in  NREQ  per-engine write strobe.
- vga_x  out  9  muxed x.
- vga_y  out  8  muxed y.
- vga_colour  out  3  muxed colour.
- vga_write  out  1  muxed write strobe.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky timeout flag.
- clear_err  in  1  synchronous clear of timeout_err.

Function
REQ-005 FSM states: IDLE, START, WAIT, RELEASE; state register and round-robin pointer (0..NREQ-1) are the only control state besides the timeout counter and error flag.
REQ-006 IDLE: when req != 0, select the first set bit at or after the pointer (wrapping), register grant one-hot, and go to START on the next edge; otherwise stay in IDLE.
REQ-007 START lasts exactly one cycle: start[g] = 1 and all other start bits are 0; the timeout counter loads 0; next state is WAIT.
REQ-008 WAIT: eng_done[g] = 1 goes to RELEASE; eng_done from non-granted engines is ignored in every state; eng_done[g] asserted during START is also accepted and goes directly to RELEASE.
REQ-009 WAIT timeout: the counter increments each cycle; when it equals TIMEOUT-1 with no done, go to RELEASE and set timeout_err.
REQ-010 RELEASE lasts one cycle with grant = 0; the pointer becomes (g+1) mod NREQ; next state is IDLE.
REQ-011 Minimum turnaround: req sampled at edge t gives grant at t+1, start at t+1 only, and the next grant no earlier than RELEASE+2.
REQ-012 The requester keeps req high until its done; after done it must drop req within one cycle or it is re-arbitrated behind the other engines (round-robin fairness: no engine is granted twice while another holds req).
REQ-013 VGA mux is combinational from the registered grant: vga_* = eng_vga_*[g] while grant[g] = 1; when grant = 0, vga_write = 0 and vga_x, vga_y, vga_colour = 0.
REQ-014 timeout_err stays high until clear_err = 1; if clear_err and a new timeout occur in the same cycle, set wins.
REQ-015 grant, start and busy are registered, glitch-free outputs.

Reset
REQ-016 reset = 0 asynchronously forces IDLE, pointer 0, grant 0, start 0, counter 0 and timeout_err 0; vga_write is then 0 through the mux.
REQ-017 Reset mid-WAIT abandons the engine with no done and no error; arbitration resumes from pointer 0 after reset is released.

Structure
REQ-018 Shared package draw_arb_pkg holds the state encoding localparams (IDLE = 0, START = 1, WAIT = 2, RELEASE = 3) and the VGA widths (X = 9, Y = 8, C = 3).
REQ-019 One combinational sub-module, rr_pick (inputs req and pointer; output one-hot pick), contains the wrap-around priority search; the mux and FSM stay in draw_arbiter.

Verification
REQ-020 A single request on req = 3'b010 -> grant = 010 at the next edge, exactly one start[1] pulse, vga_* follow engine 1 until done, then grant = 0 for one cycle and busy falls.
REQ-021 All requests held (req = 111) with done 5 cycles after each start -> grant order 0, 1, 2, 0, 1, 2, and no engine is granted twice in a row.
REQ-022 TIMEOUT = 16 with done never asserted -> release after 16 WAIT cycles, timeout_err = 1 until clear_err is pulsed, pointer advanced by one.
REQ-023 eng_done[2] pulsed while grant = 001, and eng_vga_write[2] = 1 -> no state change and vga_write reflects engine 0 only.
REQ-024 reset driven low in WAIT with grant = 100 -> grant, start and vga_write are 0 immediately (before the next edge); the first grant after reset with req = 111 is engine 0.
REQ-025 eng_done[g] asserted in the same cycle as start[g] -> RELEASE on the next edge with no timeout and the pointer advanced.
